// File: rtl/adder_pkg.sv
// adder_pkg
// Shared declarations for the serial adder/subtractor family:
//   state_t    - controller states (IDLE, RUN, DONE)
//   cnt_width  - width of the chunk counter for N chunks, never below 1 bit
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // clog2(n) collapses to 0 for n=1, which would give a zero-width counter,
  // so anything up to 2 chunks uses a single bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// fa_cell
// Single-bit full adder assembled from two half-adder stages and an OR.
// Ports:
//   a, b  in   operand bits
//   cin   in   carry in
//   s     out  sum bit
//   cout  out  carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;
  logic g1;
  logic g2;

  // First half adder combines the operands, the second folds in the carry;
  // either stage generating a carry produces the carry out.
  always_comb begin
    p    = a ^ b;
    g1   = a & b;
    s    = p ^ cin;
    g2   = p & cin;
    cout = g1 | g2;
  end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
// Multi-cycle adder/subtractor: DIGIT bits per clock through a chain of
// fa_cell slices with a registered carry, start/busy/done handshake.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request, only looked at while not busy
//   sub    in   0 = a+b, 1 = a-b (captured with start)
//   a, b   in   WIDTH-bit operands (captured with start)
//   busy   out  high while chunks are being processed
//   done   out  one-cycle pulse, result outputs valid from this cycle
//   sum    out  WIDTH-bit result, held until the next completion
//   cout   out  carry out of the MSB (subtraction: 1 = no borrow)
//   ovf    out  signed overflow
module serial_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT >= 1");
  end

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             step;
  logic             last;
  logic             finish;

  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] slice_sum;

  // Per-cycle slice: DIGIT full adders rippling from the registered carry.
  // chain[DIGIT-1] is the carry into the slice MSB, which on the final chunk
  // is the carry into bit WIDTH-1 needed for signed overflow.
  assign chain[0] = carry;

  for (genvar i = 0; i < DIGIT; i++) begin : g_slice
    fa_cell u_fa (
      .a    (opa[i]),
      .b    (opb[i]),
      .cin  (chain[i]),
      .s    (slice_sum[i]),
      .cout (chain[i+1])
    );
  end

  // New chunks enter at the MSB end so that after N chunks the first one
  // has been pushed down to bit 0. With a single chunk there is nothing
  // older to keep.
  if (DIGIT == WIDTH) begin : g_res_whole
    assign res_next = slice_sum;
  end else begin : g_res_shift
    assign res_next = {slice_sum, res[WIDTH-1:DIGIT]};
  end

  assign last   = (cnt == CW'(N - 1));
  assign finish = step & last;
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. DONE accepts a new request directly so back-to-back
  // operations cost N+1 cycles; RUN ignores start entirely.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Subtraction is a + ~b + 1: invert b on capture and seed the
  // carry with sub. The visible outputs are only written on the completion
  // edge, so partial results never leak out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        opa   <= a;
        opb   <= b ^ {WIDTH{sub}};
        carry <= sub;
        res   <= '0;
        cnt   <= '0;
      end else if (step) begin
        opa   <= opa >> DIGIT;
        opb   <= opb >> DIGIT;
        carry <= chain[DIGIT];
        res   <= res_next;
        cnt   <= cnt + CW'(1);
      end
      if (finish) begin
        sum  <= res_next;
        cout <= chain[DIGIT];
        ovf  <= chain[DIGIT-1] ^ chain[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub
// Eight serial_addsub instances (8-bit with DIGIT 1/2/4, 16-bit with DIGIT
// 1/2/4/8/16) checked against a plain-arithmetic reference model.
module tb_serial_addsub;

  localparam int NINST = 8;

  // Instance geometry: 0..2 are 8-bit, 3..7 are 16-bit.
  function automatic int wOf(input int g);
    return (g < 3) ? 8 : 16;
  endfunction

  function automatic int dOf(input int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 1;
      4: return 2;
      5: return 4;
      6: return 8;
      default: return 16;
    endcase
  endfunction

  logic             clk;
  logic             rst;
  logic [NINST-1:0] start;
  logic             sub;
  logic [15:0]      a;
  logic [15:0]      b;
  logic [NINST-1:0] busy;
  logic [NINST-1:0] done;
  logic [NINST-1:0] cout;
  logic [NINST-1:0] ovf;
  logic [15:0]      sumw [NINST];
  logic [15:0]      prevSum [NINST];

  int checks;
  int errors;

  for (genvar g = 0; g < NINST; g++) begin : dut
    localparam int W = wOf(g);
    localparam int D = dOf(g);
    logic [W-1:0] s;
    serial_addsub #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start[g]),
      .sub   (sub),
      .a     (a[W-1:0]),
      .b     (b[W-1:0]),
      .busy  (busy[g]),
      .done  (done[g]),
      .sum   (s),
      .cout  (cout[g]),
      .ovf   (ovf[g])
    );
    assign sumw[g] = 16'(s);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic modulo 2^w, borrow-free test for cout on
  // subtraction, and an out-of-range test on the true signed result for ovf.
  task automatic model(input int w, input logic [15:0] av, input logic [15:0] bv, input logic sv,
                       output logic [15:0] es, output logic ec, output logic eo);
    longint mask, ua, ub, sa, sb, r;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(av) & mask;
    ub   = longint'(bv) & mask;
    sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    if (sv) begin
      es = 16'((ua - ub) & mask);
      ec = (ua >= ub);
      r  = sa - sb;
    end else begin
      es = 16'((ua + ub) & mask);
      ec = ((ua + ub) > mask);
      r  = sa + sb;
    end
    eo = (r > (longint'(1) << (w - 1)) - 1) || (r < -(longint'(1) << (w - 1)));
  endtask

  // Issue one operation on instance g (called on a falling edge, possibly in
  // the DONE cycle of the previous one) and follow it to completion.
  // pulseAt >= 0 re-asserts start with other operands while busy.
  task automatic applyStimulus(input int g, input logic [15:0] av, input logic [15:0] bv, input logic sv,
                               input int pulseAt, input logic [15:0] pa, input logic [15:0] pb);
    int n, edges, busyCnt;
    logic stable;
    logic [15:0] es;
    logic ec, eo;
    n = wOf(g) / dOf(g);
    model(wOf(g), av, bv, sv, es, ec, eo);
    a = av;
    b = bv;
    sub = sv;
    start[g] = 1'b1;
    @(negedge clk);
    edges = 1;
    start[g] = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    sub = 1'($urandom);
    busyCnt = 0;
    stable = 1'b1;
    while (!done[g] && edges < n + 6) begin
      if (busy[g]) busyCnt++;
      if (sumw[g] !== prevSum[g]) stable = 1'b0;
      if (edges == pulseAt) begin
        start[g] = 1'b1;
        a = pa;
        b = pb;
        sub = ~sv;
      end else begin
        start[g] = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start[g] = 1'b0;
    checkOutput($sformatf("inst%0d latency", g), 32'(edges), 32'(n + 1));
    checkOutput($sformatf("inst%0d busycycles", g), 32'(busyCnt), 32'(n));
    checkOutput($sformatf("inst%0d busy_at_done", g), 32'(busy[g]), 32'(0));
    checkOutput($sformatf("inst%0d sum_stable", g), 32'(stable), 32'(1));
    checkOutput($sformatf("inst%0d sum a=%0h b=%0h sub=%0b", g, av, bv, sv), 32'(sumw[g]), 32'(es));
    checkOutput($sformatf("inst%0d cout", g), 32'(cout[g]), 32'(ec));
    checkOutput($sformatf("inst%0d ovf", g), 32'(ovf[g]), 32'(eo));
    prevSum[g] = es;
  endtask

  // Asynchronous reset in the middle of a run: outputs clear without an
  // edge, and no completion pulse follows.
  task automatic resetInRun(input int g);
    int doneSeen;
    a = 16'h40;
    b = 16'h13;
    sub = 1'b0;
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async busy", 32'(busy[g]), 32'(0));
    checkOutput("rst_async done", 32'(done[g]), 32'(0));
    checkOutput("rst_async sum", 32'(sumw[g]), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NINST; i++) prevSum[i] = '0;
    doneSeen = 0;
    repeat (wOf(g) / dOf(g) + 4) begin
      @(negedge clk);
      if (done[g]) doneSeen++;
    end
    checkOutput("rst_no_done", 32'(doneSeen), 32'(0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = '0;
    sub = 1'b0;
    a = '0;
    b = '0;
    for (int i = 0; i < NINST; i++) prevSum[i] = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NINST; i++) begin
      checkOutput($sformatf("inst%0d reset busy", i), 32'(busy[i]), 32'(0));
      checkOutput($sformatf("inst%0d reset done", i), 32'(done[i]), 32'(0));
      checkOutput($sformatf("inst%0d reset sum", i), 32'(sumw[i]), 32'(0));
      checkOutput($sformatf("inst%0d reset flags", i), 32'({cout[i], ovf[i]}), 32'(0));
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed cases");
    applyStimulus(0, 16'd100, 16'd27, 1'b0, -1, '0, '0);
    applyStimulus(1, 16'h7F, 16'h01, 1'b0, -1, '0, '0);
    applyStimulus(1, 16'hFF, 16'h01, 1'b0, -1, '0, '0);
    applyStimulus(2, 16'd5, 16'd7, 1'b1, -1, '0, '0);
    applyStimulus(2, 16'h80, 16'h01, 1'b1, -1, '0, '0);

    $display("[TB] start while busy, then back-to-back from DONE");
    applyStimulus(0, 16'h55, 16'h0F, 1'b0, 3, 16'hAA, 16'h33);
    applyStimulus(0, 16'h40, 16'h13, 1'b1, -1, '0, '0);
    @(negedge clk);

    $display("[TB] reset during run");
    resetInRun(0);
    applyStimulus(0, 16'hC3, 16'h5A, 1'b1, -1, '0, '0);
    @(negedge clk);

    $display("[TB] randomised sweep");
    for (int g = 3; g < NINST; g++) begin
      for (int k = 0; k < 1000; k++) begin
        applyStimulus(g, 16'($urandom), 16'($urandom), 1'($urandom), -1, '0, '0);
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised multi-cycle adder/subtractor, the sequential successor to the combinational half-adder cell. Operates on WIDTH-bit two's-complement/unsigned operands, processing DIGIT bits per clock through a chained full-adder slice with a registered carry. Start/busy/done handshake. Used where area matters more than latency, and as the arithmetic unit for the lab datapath.

## Interface
- WIDTH, 8, operand and result width in bits; must be at least 2.
- DIGIT, 1, bits processed per cycle; must be at least 1. WIDTH % DIGIT == 0 is required and is checked at elaboration.
- N (localparam), WIDTH/DIGIT, number of processing cycles.

- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- sub  in  1  0 = a+b, 1 = a−b; captured with start.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result registers valid from this cycle.
- sum  out  WIDTH  result, held until the next completion.
- cout  out  1  carry out of the MSB; for subtraction, 1 = no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if start=1, go to RUN, capture operands, clear the counter.
  - Capture: opa←a, opb←b XOR {WIDTH{sub}}, carry←sub.
- RUN, each cycle:
  - Add DIGIT LSBs of opa and opb with carry.
  - Shift opa and opb right by DIGIT.
  - Shift the DIGIT-bit partial result into the MSB end of the internal result shift register.
  - Update carry; increment the counter.
  - On the chunk with count N−1:
    - Load sum←the complete result, cout←final carry, ovf←(carry into bit WIDTH−1) XOR final carry.
    - Go to DONE.
- DONE: done=1, busy=0. If start=1, accept a new operation and go to RUN (back-to-back). Otherwise go to IDLE.
- start while busy=1 is ignored; the operation in flight is unaffected.
- Operand inputs are don't-care except in the start-accept cycle.
- sum, cout and ovf change only on the completion edge. They never show partial results.
- The counter needs clog2(N) bits, minimum 1. All arithmetic is modulo 2^WIDTH.

## Timing
- Reset (asynchronous, any time, including mid-RUN):
  - state=IDLE; busy=0, done=0.
  - sum=0, cout=0, ovf=0; internal registers 0.
  - The operation in progress is discarded with no done pulse.
- Let start be accepted at edge E0:
  - busy=1 from E0 until EN.
  - Chunks are processed at edges E1..EN.
  - done=1 and the new sum/cout/ovf appear after EN, N+1 edges after the accept edge.
  - done deasserts after EN+1 unless it is re-asserted by a new completion.
- Throughput: N+1 cycles per operation in back-to-back use, because start is accepted in the DONE cycle.
- DIGIT=WIDTH gives N=1: busy is high for 1 cycle and done comes 2 edges after accept.

## Structure
- Shared package adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the localparam helper for counter width (clog2 with minimum 1).
- One sub-module, fa_cell: a single-bit full adder built from two half-adder equations plus an OR.
  - It is instantiated DIGIT times in a generate chain to form the per-cycle slice.
  - The carry into the slice MSB is exported for ovf.

## Test plan
- WIDTH=8, DIGIT=1: start with a=100, b=27, sub=0 → done after 9 edges; sum=127, cout=0, ovf=0; busy high for exactly 8 cycles.
- WIDTH=8, DIGIT=2:
  - a=0x7F, b=0x01, add → sum=0x80, cout=0, ovf=1.
  - a=0xFF, b=0x01, add → sum=0x00, cout=1, ovf=0.
- WIDTH=8, DIGIT=4:
  - a=5, b=7, sub=1 → sum=0xFE, cout=0, ovf=0.
  - a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1.
- Pulse start again mid-RUN with different operands → ignored; first result unchanged. Then assert start in the DONE cycle → second operation completes N+1 edges later with the correct result.
- Assert rst during RUN cycle 3 → busy=0, done=0, sum=0 immediately without waiting for a clock edge; no done pulse follows. A fresh operation afterwards gives the correct result.
- Randomised sweep, WIDTH=16 with DIGIT ∈ {1,2,4,8,16}: 1000 operations each → sum, cout and ovf match the reference model; sum stable between done pulses.
